// File: rtl/load_store_unit.sv
// Load/store unit: word index, byte-lane mask and shifted store data toward Data_memory,
// plus load formatting. Accesses that cross a word boundary take two cycles.
module load_store_unit #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk_o,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        mem_err,
  output logic [31:0] addrL_LSU,
  output logic [31:0] addrS_LSU,
  output logic [31:0] store,
  output logic [3:0]  mask,
  output logic        wr_E,
  output logic        cs_E,
  output logic        Data_Memory_on,
  input  logic [31:0] data_rd
);

  typedef enum logic {IDLE, SPLIT2} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DMEM_DEPTH);

  state_t      state_q;
  logic [31:0] hold_q;

  logic [1:0]  k;
  logic [31:0] w;
  logic        is_h, is_w, f3_ok, split, err, in_split2;
  logic [3:0]  mask_first, mask_second;
  logic [5:0]  shamt2;
  logic [31:0] lo, hi, sh, fmt, idx;

  assign k         = addr[1:0];
  assign w         = {2'b00, addr[31:2]};
  assign is_h      = (funct3[1:0] == 2'b01);
  assign is_w      = (funct3[1:0] == 2'b10);
  assign in_split2 = (state_q == SPLIT2);

  // Unsigned widths exist for loads only.
  assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (!req_wr && ((funct3 == 3'b100) || (funct3 == 3'b101)));
  assign split = (is_w && (k != 2'd0)) || (is_h && (k == 2'd3));
  assign err   = !f3_ok || (w >= DEPTH_W) || (split && (w == DEPTH_W - 32'd1));

  // Lanes shifted past bit 3 belong to the second word and are dropped here.
  assign mask_first  = is_w ? (4'b1111 << k) : is_h ? (4'b0011 << k) : (4'b0001 << k);
  assign mask_second = is_w ? (4'b1111 >> (3'd4 - {1'b0, k})) : 4'b0001;
  assign shamt2      = 6'd32 - {1'b0, k, 3'b000};

  assign lo = in_split2 ? hold_q  : data_rd;
  assign hi = in_split2 ? data_rd : 32'd0;
  assign sh = 32'({hi, lo} >> {k, 3'b000});

  always_comb begin
    case (funct3)
      3'b000:  fmt = {{24{sh[7]}}, sh[7:0]};
      3'b100:  fmt = {24'd0, sh[7:0]};
      3'b001:  fmt = {{16{sh[15]}}, sh[15:0]};
      3'b101:  fmt = {16'd0, sh[15:0]};
      default: fmt = sh;
    endcase
  end

  always_comb begin
    load_data      = 32'd0;
    stall          = 1'b0;
    mem_err        = 1'b0;
    idx            = 32'd0;
    store          = 32'd0;
    mask           = 4'b0000;
    wr_E           = 1'b0;
    cs_E           = 1'b1;
    Data_Memory_on = 1'b0;
    if (reset) begin
      if (in_split2) begin
        cs_E           = 1'b0;
        Data_Memory_on = 1'b1;
        wr_E           = req_wr;
        idx            = w + 32'd1;
        mask           = req_wr ? mask_second : 4'b0000;
        store          = wdata >> shamt2;
        load_data      = req_wr ? 32'd0 : fmt;
      end else if (req_valid) begin
        if (err) begin
          mem_err = 1'b1;
        end else begin
          cs_E           = 1'b0;
          Data_Memory_on = 1'b1;
          wr_E           = req_wr;
          idx            = w;
          mask           = req_wr ? mask_first : 4'b0000;
          store          = wdata << {k, 3'b000};
          stall          = split;
          load_data      = (!req_wr && !split) ? fmt : 32'd0;
        end
      end
    end
  end

  assign addrL_LSU = idx;
  assign addrS_LSU = idx;

  always_ff @(posedge clk_o or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (req_valid && !err && split) begin
          state_q <= SPLIT2;
          hold_q  <= data_rd;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-wide Data_memory model driven by the DUT, checked
// against a byte-addressed reference memory and expected load values.
module tb_load_store_unit;

  logic        clk_o, reset, req_valid, req_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, load_data, addrL_LSU, addrS_LSU, store, data_rd;
  logic        stall, mem_err, wr_E, cs_E, Data_Memory_on;
  logic [3:0]  mask;

  load_store_unit #(.DMEM_DEPTH(256)) dut (
    .clk_o(clk_o), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
    .funct3(funct3), .addr(addr), .wdata(wdata), .load_data(load_data),
    .stall(stall), .mem_err(mem_err), .addrL_LSU(addrL_LSU), .addrS_LSU(addrS_LSU),
    .store(store), .mask(mask), .wr_E(wr_E), .cs_E(cs_E),
    .Data_Memory_on(Data_Memory_on), .data_rd(data_rd)
  );

  always #5 clk_o = ~clk_o;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_b [0:1023];
  bit          mem_clr;
  int          n_cmp, n_bad;
  logic [31:0] cap_idx [2];
  logic [31:0] cap_st  [2];
  logic [3:0]  cap_mask [2];

  always @(negedge clk_o) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (Data_Memory_on && !cs_E && wr_E && addrS_LSU < 32'd256) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[addrS_LSU[7:0]][8*i +: 8] <= store[8*i +: 8];
    end
  end
  assign data_rd = (addrL_LSU < 32'd256) ? mem[addrL_LSU[7:0]] : 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int sz;
    bit legal, spl, err;
    logic [31:0] w, exp_ld;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
            (!wr && (f3 == 3'b100 || f3 == 3'b101));
    spl   = (int'(a % 4) + sz) > 4;
    w     = a / 4;
    err   = !legal || a >= 32'd1024 || (spl && w == 32'd255);
    exp_ld = 32'd0;
    if (!err) begin
      for (int i = 0; i < sz; i++) exp_ld |= 32'(ref_b[a + 32'(i)]) << (8 * i);
      if (!f3[2] && sz < 4 && exp_ld[8*sz-1]) exp_ld |= 32'hFFFF_FFFF << (8 * sz);
    end
    @(posedge clk_o); #1;
    req_valid = 1'b1; req_wr = wr; funct3 = f3; addr = a; wdata = wd;
    #3;
    cap_idx[0] = addrS_LSU; cap_st[0] = store; cap_mask[0] = mask;
    if (err) begin
      chk("err.mem_err", 32'(mem_err), 32'd1);
      chk("err.cs_E", 32'(cs_E), 32'd1);
      chk("err.stall", 32'(stall), 32'd0);
      chk("err.mask", 32'(mask), 32'd0);
      chk("err.load_data", load_data, 32'd0);
    end else begin
      chk("mem_err", 32'(mem_err), 32'd0);
      chk("stall.first", 32'(stall), 32'(spl));
      chk("cs_E", 32'(cs_E), 32'd0);
      chk("wr_E", 32'(wr_E), 32'(wr));
      chk("idx.first", addrL_LSU, w);
      if (!wr) chk("load.mask", 32'(mask), 32'd0);
      if (spl) begin
        @(posedge clk_o); #4;
        cap_idx[1] = addrS_LSU; cap_st[1] = store; cap_mask[1] = mask;
        chk("stall.second", 32'(stall), 32'd0);
        chk("idx.second", addrS_LSU, w + 32'd1);
      end
      if (!wr) chk("load_data", load_data, exp_ld);
      else for (int i = 0; i < sz; i++) ref_b[a + 32'(i)] = wd[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic        wr;
    int          r;
    clk_o = 0; reset = 0; req_valid = 0; req_wr = 0; funct3 = 0; addr = 0; wdata = 0;
    mem_clr = 1; n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'd0;
    #12;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.cs_E", 32'(cs_E), 32'd1);
    chk("rst.wr_E", 32'(wr_E), 32'd0);
    chk("rst.mask", 32'(mask), 32'd0);
    chk("rst.dmem_on", 32'(Data_Memory_on), 32'd0);
    chk("rst.mem_err", 32'(mem_err), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    #4; mem_clr = 0; reset = 1;

    do_op(1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw.idx", cap_idx[0], 32'd4);
    chk("sw.mask", 32'(cap_mask[0]), 32'hF);
    chk("sw.store", cap_st[0], 32'hDEADBEEF);
    do_op(0, 3'b000, 32'h13, 32'd0);
    chk("lb.fixed", load_data, 32'hFFFFFFDE);
    do_op(0, 3'b100, 32'h13, 32'd0);
    chk("lbu.fixed", load_data, 32'h000000DE);

    do_op(1, 3'b001, 32'h22, 32'h0000ABCD);
    chk("sh.idx", cap_idx[0], 32'd8);
    chk("sh.mask", 32'(cap_mask[0]), 32'hC);
    chk("sh.store", cap_st[0], 32'hABCD0000);
    do_op(0, 3'b001, 32'h22, 32'd0);
    chk("lh.fixed", load_data, 32'hFFFFABCD);

    do_op(1, 3'b010, 32'h05, 32'h11223344);
    chk("ssw.idx1", cap_idx[0], 32'd1);
    chk("ssw.mask1", 32'(cap_mask[0]), 32'hE);
    chk("ssw.store1", cap_st[0], 32'h22334400);
    chk("ssw.idx2", cap_idx[1], 32'd2);
    chk("ssw.mask2", 32'(cap_mask[1]), 32'h1);
    chk("ssw.store2", cap_st[1], 32'h00000011);
    do_op(0, 3'b010, 32'h05, 32'd0);
    chk("slw.fixed", load_data, 32'h11223344);

    do_op(1, 3'b010, 32'h04, 32'h80123456);
    do_op(1, 3'b010, 32'h08, 32'h6543217F);
    do_op(0, 3'b001, 32'h07, 32'd0);
    chk("slh.fixed", load_data, 32'h00007F80);
    do_op(0, 3'b101, 32'h07, 32'd0);
    chk("slhu.fixed", load_data, 32'h00007F80);

    do_op(0, 3'b010, 32'h3FD, 32'd0);
    do_op(0, 3'b011, 32'h20, 32'd0);
    do_op(0, 3'b010, 32'h400, 32'd0);
    do_op(1, 3'b100, 32'h20, 32'd0);

    // Reset cut during the second word of a split store.
    @(posedge clk_o); #1;
    req_valid = 1; req_wr = 1; funct3 = 3'b010; addr = 32'h31; wdata = 32'hCAFEF00D;
    #3; chk("cut.stall1", 32'(stall), 32'd1);
    @(posedge clk_o); #1; reset = 0; #1;
    chk("cut.stall", 32'(stall), 32'd0);
    chk("cut.cs_E", 32'(cs_E), 32'd1);
    chk("cut.mask", 32'(mask), 32'd0);
    for (int i = 0; i < 3; i++) ref_b[32'h31 + i] = wdata[8*i +: 8];
    req_valid = 0; #2; reset = 1;
    do_op(0, 3'b010, 32'h30, 32'd0);
    do_op(0, 3'b010, 32'h34, 32'd0);

    for (int n = 0; n < 600; n++) begin
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 15);
      if (r == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      r = $urandom_range(0, 19);
      if (r == 0)      a = $urandom_range(0, 1279);
      else if (r == 1) a = $urandom_range(1016, 1023);
      else if (r < 10) a = $urandom_range(0, 63);
      else             a = $urandom_range(0, 1023);
      wd = $urandom;
      do_op(wr, f3, a, wd);
    end

    @(posedge clk_o); #1; req_valid = 0;
    @(posedge clk_o); #1;
    for (int i = 0; i < 256; i++)
      chk("mem.word", mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
